// File: rtl/xbar_pkg.sv
// Shared crossbar definitions: clog2 helper, valid-bit position and
// slice-index helpers for the grant matrix, out_bus and occupancy buses.
package xbar_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int k = 0; k < 31; k++) begin
            if ((1 << r) < n) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

    // The valid flag sits directly above the payload in each out_bus slice.
    function automatic int valid_pos(input int width);
        return width;
    endfunction

    // grant[o*PORTS+i]: output o grants input i.
    function automatic int grant_bit(input int o, input int i,
                                     input int ports);
        return o * ports + i;
    endfunction

    function automatic int bus_lo(input int o, input int width);
        return o * (width + 1);
    endfunction

    function automatic int occ_lo(input int o, input int depth);
        return o * (clog2(depth) + 1);
    endfunction

endpackage

// File: rtl/voq_fifo.sv
// One virtual output queue: synchronous FIFO with head, empty, full, count.
// Ports: clk, rst (async active-low), push/din, pop, head, empty, full, count.
module voq_fifo
    import xbar_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      pop,
    input  logic [WIDTH-1:0]          din,
    output logic [WIDTH-1:0]          head,
    output logic                      empty,
    output logic                      full,
    output logic [clog2(DEPTH):0]     count
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];
    assign count   = cnt;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: an entry is only visible once counted.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/voq_input_queue.sv
// Crossbar input buffer: steers ingress words into per-output VOQs.
// Ports: ingress valid/ready/data/dest, grant matrix, req, out_bus, occupancy.
module voq_input_queue
    import xbar_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int PORTS = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [clog2(PORTS)-1:0]              id,
    input  logic                                 in_valid,
    input  logic [WIDTH-1:0]                     in_data,
    input  logic [clog2(PORTS)-1:0]              in_dest,
    output logic                                 in_ready,
    input  logic [PORTS*PORTS-1:0]               grant,
    output logic [PORTS-1:0]                     req,
    output logic [PORTS*(WIDTH+1)-1:0]           out_bus,
    output logic [PORTS*(clog2(DEPTH)+1)-1:0]    occupancy
);

    localparam int PW = clog2(PORTS);
    localparam int CW = clog2(DEPTH) + 1;

    logic [PORTS-1:0] full;
    logic [PORTS-1:0] empty;
    logic [PORTS-1:0] g;
    logic [PORTS-1:0] push;
    logic [PORTS-1:0] sel;
    logic [WIDTH-1:0] head [PORTS];
    logic [CW-1:0]    cnt  [PORTS];
    logic             take;

    // Ready looks only at the addressed queue; a pending pop does not
    // free a slot for a push in the same cycle.
    assign in_ready = ~full[in_dest];
    assign take     = in_valid & in_ready;
    assign req      = ~empty;

    for (genvar o = 0; o < PORTS; o++) begin : g_voq
        logic [PORTS-1:0] gcol;

        assign gcol    = grant[grant_bit(o, 0, PORTS) +: PORTS];
        assign g[o]    = gcol[id];
        assign push[o] = take & (in_dest == PW'(o));
        assign sel[o]  = g[o] & ~empty[o];

        voq_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[o]),
            .pop   (sel[o]),
            .din   (in_data),
            .head  (head[o]),
            .empty (empty[o]),
            .full  (full[o]),
            .count (cnt[o])
        );

        // Data is forced to zero when not selected so stale heads never
        // leak onto the shared output mux.
        assign out_bus[bus_lo(o, WIDTH) + valid_pos(WIDTH)] = sel[o];
        assign out_bus[bus_lo(o, WIDTH) +: WIDTH] =
            sel[o] ? head[o] : '0;
        assign occupancy[occ_lo(o, DEPTH) +: CW] = cnt[o];
    end

endmodule

// File: tb/tb_voq_input_queue.sv
// Self-checking bench for voq_input_queue: directed table, async reset,
// wrap sequence and randomized traffic against a queue-based model.
module tb_voq_input_queue;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int PORTS = 4;
    localparam int BW    = PORTS * (WIDTH + 1);
    localparam int OW    = PORTS * 3;

    logic             clk;
    logic             rst;
    logic [1:0]       id;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_dest;
    logic             in_ready;
    logic [15:0]      grant;
    logic [3:0]       req;
    logic [BW-1:0]    out_bus;
    logic [OW-1:0]    occupancy;

    int checks;
    int errors;

    logic [7:0] q [PORTS][$];
    logic [7:0] pushed [$];
    logic [7:0] popped [$];

    typedef struct {
        logic          v;
        logic [1:0]    dest;
        logic [7:0]    data;
        logic [15:0]   gr;
        logic          e_ready;
        logic [3:0]    e_req;
        logic [BW-1:0] e_bus;
        logic [OW-1:0] e_occ;
    } vec_t;

    vec_t tv [21];

    voq_input_queue #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PORTS (PORTS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .id        (id),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .in_ready  (in_ready),
        .grant     (grant),
        .req       (req),
        .out_bus   (out_bus),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] d,
                         input logic [7:0] dat, input logic [15:0] gr);
        in_valid = v;
        in_dest  = d;
        in_data  = dat;
        grant    = gr;
    endtask

    // Model step: expectations come from the queues' contents only.
    task automatic mstep(input logic v, input logic [1:0] d,
                         input logic [7:0] dat, input logic [15:0] gr,
                         input string tag);
        logic          e_ready;
        logic [3:0]    e_req;
        logic [BW-1:0] e_bus;
        logic [OW-1:0] e_occ;
        logic [3:0]    gpop;
        int            sz;
        drive(v, d, dat, gr);
        #1;
        e_ready = (q[d].size() < DEPTH);
        e_req   = '0;
        e_bus   = '0;
        e_occ   = '0;
        gpop    = '0;
        for (int o = 0; o < PORTS; o++) begin
            sz = q[o].size();
            e_req[o] = (sz != 0);
            e_occ[o*3 +: 3] = 3'(sz);
            if (gr[o*PORTS + int'(id)] && sz > 0) begin
                gpop[o] = 1'b1;
                e_bus[o*9 +: 9] = {1'b1, q[o][0]};
            end
        end
        check({tag, " in_ready"}, 64'(in_ready), 64'(e_ready));
        check({tag, " req"}, 64'(req), 64'(e_req));
        check({tag, " out_bus"}, 64'(out_bus), 64'(e_bus));
        check({tag, " occupancy"}, 64'(occupancy), 64'(e_occ));
        if (gpop[0]) popped.push_back(out_bus[7:0]);
        @(posedge clk);
        for (int o = 0; o < PORTS; o++) begin
            if (gpop[o]) void'(q[o].pop_front());
        end
        if (v && e_ready) q[d].push_back(dat);
        #1;
    endtask

    task automatic clear_model();
        for (int o = 0; o < PORTS; o++) q[o].delete();
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b0;
        id       = 2'd0;
        drive(1'b0, 2'd0, 8'h00, 16'h0000);

        // inputs v,dest,data,grant | ready, req, out_bus, occupancy
        tv[0]  = '{1, 0, 8'hAA, 16'h0000, 1, 4'b0000, 36'h0, 12'h000};
        tv[1]  = '{1, 1, 8'hBB, 16'h0000, 1, 4'b0001, 36'h0, 12'h001};
        tv[2]  = '{1, 2, 8'hCC, 16'h0000, 1, 4'b0011, 36'h0, 12'h009};
        tv[3]  = '{1, 3, 8'hDD, 16'h0000, 1, 4'b0111, 36'h0, 12'h049};
        tv[4]  = '{0, 0, 8'h00, 16'h0000, 1, 4'b1111, 36'h0, 12'h249};
        tv[5]  = '{1, 0, 8'h01, 16'h0000, 1, 4'b1111, 36'h0, 12'h249};
        tv[6]  = '{1, 0, 8'h02, 16'h0000, 1, 4'b1111, 36'h0, 12'h24A};
        tv[7]  = '{1, 0, 8'h03, 16'h0000, 1, 4'b1111, 36'h0, 12'h24B};
        tv[8]  = '{1, 0, 8'h04, 16'h0000, 0, 4'b1111, 36'h0, 12'h24C};
        tv[9]  = '{1, 2, 8'hEE, 16'h0000, 1, 4'b1111, 36'h0, 12'h24C};
        tv[10] = '{0, 2, 8'h00, 16'h0100, 1, 4'b1111,
                   36'h007300000, 12'h28C};
        tv[11] = '{0, 2, 8'h00, 16'h0100, 1, 4'b1111,
                   36'h007B80000, 12'h24C};
        tv[12] = '{0, 2, 8'h00, 16'h0100, 1, 4'b1011, 36'h0, 12'h20C};
        tv[13] = '{0, 2, 8'h00, 16'h2222, 1, 4'b1011, 36'h0, 12'h20C};
        tv[14] = '{0, 2, 8'h00, 16'h2222, 1, 4'b1011, 36'h0, 12'h20C};
        tv[15] = '{1, 1, 8'h11, 16'h0000, 1, 4'b1011, 36'h0, 12'h20C};
        tv[16] = '{1, 1, 8'h12, 16'h0010, 1, 4'b1011,
                   36'h000037600, 12'h214};
        tv[17] = '{0, 1, 8'h00, 16'h0010, 1, 4'b1011,
                   36'h000022200, 12'h214};
        tv[18] = '{0, 3, 8'h00, 16'h1000, 1, 4'b1011,
                   36'hEE8000000, 12'h20C};
        tv[19] = '{0, 3, 8'h00, 16'h1000, 1, 4'b0011, 36'h0, 12'h00C};
        tv[20] = '{0, 3, 8'h00, 16'h0000, 1, 4'b0011, 36'h0, 12'h00C};

        // Reset state, visible without any clock edge.
        #1;
        check("rst req", 64'(req), 64'h0);
        check("rst out_bus", 64'(out_bus), 64'h0);
        check("rst occupancy", 64'(occupancy), 64'h0);
        check("rst in_ready", 64'(in_ready), 64'h1);
        #11;
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int k = 0; k < 21; k++) begin
            drive(tv[k].v, tv[k].dest, tv[k].data, tv[k].gr);
            #1;
            check($sformatf("vec%0d in_ready", k),
                  64'(in_ready), 64'(tv[k].e_ready));
            check($sformatf("vec%0d req", k),
                  64'(req), 64'(tv[k].e_req));
            check($sformatf("vec%0d out_bus", k),
                  64'(out_bus), 64'(tv[k].e_bus));
            check($sformatf("vec%0d occupancy", k),
                  64'(occupancy), 64'(tv[k].e_occ));
            @(posedge clk);
            #1;
        end

        // Asynchronous reset mid-operation with a transfer pending.
        drive(1'b1, 2'd1, 8'h55, 16'hFFFF);
        #2;
        rst = 1'b0;
        #1;
        check("mid rst req", 64'(req), 64'h0);
        check("mid rst out_bus", 64'(out_bus), 64'h0);
        check("mid rst occupancy", 64'(occupancy), 64'h0);
        check("mid rst in_ready", 64'(in_ready), 64'h1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst edge no push", 64'(occupancy), 64'h0);
        clear_model();
        drive(1'b0, 2'd0, 8'h00, 16'h0000);
        @(posedge clk);
        #1;

        // Wrap: interleaved push/pop on VOQ0 across 3*DEPTH entries.
        for (int k = 0; k < 2; k++) begin
            pushed.push_back(8'(8'h10 + k));
            mstep(1'b1, 2'd0, 8'(8'h10 + k), 16'h0000, "wrap fill");
        end
        for (int k = 2; k < 2 + 3 * DEPTH; k++) begin
            pushed.push_back(8'(8'h10 + k));
            mstep(1'b1, 2'd0, 8'(8'h10 + k), 16'h0001, "wrap xfer");
            check("wrap occ bound", 64'(occupancy[2:0] <= 3'(DEPTH)), 64'h1);
        end
        for (int k = 0; k < 3; k++) begin
            mstep(1'b0, 2'd0, 8'h00, 16'h0001, "wrap drain");
        end
        check("wrap count", 64'(popped.size()), 64'(pushed.size()));
        for (int k = 0; k < popped.size() && k < pushed.size(); k++) begin
            check($sformatf("wrap order%0d", k),
                  64'(popped[k]), 64'(pushed[k]));
        end

        // Randomized traffic with a non-zero input index.
        drive(1'b0, 2'd0, 8'h00, 16'h0000);
        rst = 1'b0;
        #3;
        id = 2'd2;
        clear_model();
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 400; k++) begin
            mstep(1'($urandom_range(0, 3) != 0),
                  2'($urandom_range(0, 3)),
                  8'($urandom),
                  16'($urandom) & 16'($urandom),
                  "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/voq_input_queue.md
# voq_input_queue

Parametrised input-port buffer for the crossbar, successor to the single-queue input stage. Incoming words are steered by destination into per-output virtual output queues (VOQs), which removes head-of-line blocking. Each VOQ raises a request to its output arbiter and pops on that arbiter's grant. One instance sits at each crossbar input, between the ingress link and the per-output arbiters/muxes.

## Interface
- WIDTH, 8, payload bits per word
- DEPTH, 4, entries per VOQ; power of two, ≥2
- PORTS, 4, crossbar outputs = inputs; power of two, ≥2
- PW, $clog2(PORTS), derived; not overridable
- clk  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- id  in  PW  this instance's input index; static after reset
- in_valid  in  1  ingress word present
- in_data  in  WIDTH  ingress payload
- in_dest  in  PW  destination output of in_data
- in_ready  out  1  VOQ[in_dest] can accept; transfer = in_valid & in_ready
- grant  in  PORTS*PORTS  grant[o*PORTS+i]: output o grants input i; only bits with i==id are used
- req  out  PORTS  req[o] = VOQ[o] non-empty
- out_bus  out  PORTS*(WIDTH+1)  slice o = {valid, head of VOQ[o]}; MSB of each slice is valid
- occupancy  out  PORTS*($clog2(DEPTH)+1)  slice o = entry count of VOQ[o]

## Operation
- Push: on transfer, in_data is written to the tail of VOQ[in_dest]; that count +1.
- in_ready = !full[in_dest], combinational from registered state and in_dest; independent of grant (no pop-for-push bypass when full).
- Pop: at the edge where g[o] = grant[o*PORTS+id] is high and VOQ[o] is non-empty, the head is removed; count −1.
- out_bus slice o = {1, head[o]} when g[o] & !empty[o]; otherwise all zeros (data masked to 0, not left stale).
- A grant to an empty VOQ is ignored: no pop, valid=0, no pointer movement.
- Several VOQs may pop in one cycle (one per granted output); each is independent.
- Push and pop on the same non-empty VOQ in one cycle: both occur, count unchanged.
- Push to an empty VOQ: no bypass; the word is visible at the head (req high) the following cycle.
- Pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits, range 0..DEPTH.
- Grant bits for i≠id have no effect.

## Timing
- Reset (rst=0, asynchronous): all pointers and counts cleared, contents discarded. Outputs immediately: req=0, out_bus=0, occupancy=0, in_ready=1.
- Reset asserted mid-operation: same result regardless of pending transfers; a transfer at the deasserting edge is not taken if rst is still low at that edge.
- Latency, ingress to req: 1 cycle. Latency, grant to out_bus valid: 0 cycles (combinational). The head advances at the granting edge.
- in_ready, req, out_bus and occupancy are glitch-relevant combinational outputs of registered state plus in_dest/grant only; there is no path from in_data.

## Structure
- xbar_pkg holds shared constants and helpers: clog2 function, valid-bit position (WIDTH), and the slice-index macros for grant, out_bus and occupancy. The arbiters and output muxes use the same definitions.
- One sub-module: voq_fifo (WIDTH, DEPTH), a synchronous FIFO with push, pop, head, empty, full and count. It is instantiated PORTS times by a generate loop. The top level does steering, grant extraction and output masking only.

## Test plan
- Reset then idle: rst low mid-cycle → req=0, out_bus=0, occupancy=0, in_ready=1 asynchronously.
- id=0. Push AA→0, BB→1, CC→2, DD→3 on consecutive cycles → req=4'b1111, each occupancy=1, no grants → contents held.
- HOL check: fill VOQ0 to DEPTH (in_ready low for dest 0), then push EE→2 → accepted. grant bit for (o=2, i=0) → out_bus[2]={1,CC} then {1,EE}; VOQ0 untouched.
- Foreign grant: grant=16'h2222 (only i=1 bits) with id=0 → no pop, all out_bus valid=0, occupancy unchanged.
- Simultaneous push/pop on VOQ1 holding 2 entries → count stays 2, order preserved. Grant to empty VOQ3 → valid=0, count 0, no underflow.
- Wrap: 3·DEPTH interleaved push/pop on VOQ0 with an incrementing pattern → output sequence matches input exactly, count never exceeds DEPTH.
